// File: rtl/req_scheduler.sv
// Round-robin scheduler feeding row-request IDs from several requester streams
// into the row-request manager, capping in-flight rows by watching TX row footers.
module req_scheduler #(
  parameter int REQ_ID_WIDTH    = 32,
  parameter int NUM_SRC         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            ENABLE,
  input  logic [NUM_SRC*REQ_ID_WIDTH-1:0] SRC_REQ_ID,
  input  logic [NUM_SRC-1:0]              SRC_REQ_VALID,
  output logic [NUM_SRC-1:0]              SRC_REQ_READY,
  output logic [REQ_ID_WIDTH-1:0]         REQ_ID_OUT,
  output logic                            REQ_ID_VALID,
  input  logic                            READY_FOR_REQ,
  output logic [2:0]                      REQ_SRC,
  input  logic                            TX_TVALID,
  input  logic                            TX_TREADY,
  input  logic                            TX_TLAST,
  output logic [3:0]                      OUTSTANDING,
  output logic                            ERR_UNDERFLOW
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                  r_state;
  logic [SW-1:0]           r_last_grant;
  logic [3:0]              r_outstanding;
  logic                    r_err;
  logic                    r_valid;
  logic [REQ_ID_WIDTH-1:0] r_req_id;
  logic [2:0]              r_req_src;

  logic [REQ_ID_WIDTH-1:0] w_ids [NUM_SRC];
  logic [SW-1:0]           w_winner;
  logic                    w_found;
  logic                    w_elig;
  logic                    w_done;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ids
    assign w_ids[g] = SRC_REQ_ID[g*REQ_ID_WIDTH +: REQ_ID_WIDTH];
  end

  // Rotating priority: search starts just after the most recent grant.
  always_comb begin : p_arb
    int v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      v_idx = (int'(r_last_grant) + k) % NUM_SRC;
      if (!w_found && SRC_REQ_VALID[v_idx[SW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_idx[SW-1:0];
      end
    end
  end

  assign w_elig = resetn && (r_state == IDLE) && ENABLE && w_found &&
                  (r_outstanding < 4'(MAX_OUTSTANDING));
  assign w_done = TX_TVALID & TX_TREADY & TX_TLAST;

  assign SRC_REQ_READY = w_elig ? (ONE_HOT0 << w_winner) : '0;
  assign REQ_ID_OUT    = r_req_id;
  assign REQ_ID_VALID  = r_valid;
  assign REQ_SRC       = r_req_src;
  assign OUTSTANDING   = r_outstanding;
  assign ERR_UNDERFLOW = r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_valid       <= 1'b0;
      r_req_id      <= '0;
      r_req_src     <= '0;
      r_last_grant  <= SW'(NUM_SRC - 1);
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_elig) begin
            r_state      <= OFFER;
            r_valid      <= 1'b1;
            r_req_id     <= w_ids[w_winner];
            r_req_src    <= 3'(w_winner);
            r_last_grant <= w_winner;
          end
        end
        OFFER: begin
          if (READY_FOR_REQ) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase

      // A completion with nothing in flight is flagged; a same-cycle grant still counts.
      if (w_done && (r_outstanding == 4'd0)) begin
        r_err         <= 1'b1;
        r_outstanding <= w_elig ? 4'd1 : 4'd0;
      end else if (w_elig && !w_done) begin
        r_outstanding <= r_outstanding + 4'd1;
      end else if (!w_elig && w_done) begin
        r_outstanding <= r_outstanding - 4'd1;
      end
    end
  end

endmodule

// File: doc/req_scheduler.md
Name: req_scheduler

Overview:
Round-robin scheduler that sits upstream of the row-request manager. It arbitrates row-request IDs from up to 8 requester streams onto the manager's single request input. It limits in-flight rows to MAX_OUTSTANDING by observing row-footer completions on the manager's TX stream.

Parameters:
REQ_ID_WIDTH, 32, width of one row-request ID
NUM_SRC, 4, number of requester streams (legal 2..8)
MAX_OUTSTANDING, 4, max requests granted but not yet completed (legal 1..15)

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous active-low reset
ENABLE  input  1  1 = arbitration allowed; 0 = no new grants
SRC_REQ_ID  input  NUM_SRC*REQ_ID_WIDTH  request ID of source i at bits [i*REQ_ID_WIDTH +: REQ_ID_WIDTH]
SRC_REQ_VALID  input  NUM_SRC  per-source request valid
SRC_REQ_READY  output  NUM_SRC  per-source ready, one-hot or zero (combinational)
REQ_ID_OUT  output  REQ_ID_WIDTH  registered request ID to the manager
REQ_ID_VALID  output  1  registered valid to the manager
READY_FOR_REQ  input  1  manager ready
REQ_SRC  output  3  index of the source whose request is in REQ_ID_OUT
TX_TVALID  input  1  monitor tap of the manager TX stream
TX_TREADY  input  1  monitor tap
TX_TLAST  input  1  monitor tap; TVALID&TREADY&TLAST = one row completed
OUTSTANDING  output  4  current in-flight count
ERR_UNDERFLOW  output  1  sticky: a completion was seen with OUTSTANDING==0

Behaviour:
- Reset (async assert, sync deassert edge): REQ_ID_VALID=0, REQ_ID_OUT=0, REQ_SRC=0, OUTSTANDING=0, ERR_UNDERFLOW=0, state=IDLE, last_grant=NUM_SRC-1 so source 0 wins first. SRC_REQ_READY=0 while resetn=0.
- States: IDLE (REQ_ID_VALID=0) and OFFER (REQ_ID_VALID=1).
- eligible = state==IDLE & ENABLE & OUTSTANDING<MAX_OUTSTANDING & |SRC_REQ_VALID.
- Winner = first valid source searching last_grant+1, last_grant+2, ... modulo NUM_SRC.
- SRC_REQ_READY[winner]=1 only when eligible (combinational); all other bits are 0.
- Source handshake in cycle N latches REQ_ID_OUT=that source's ID and REQ_SRC=winner, sets last_grant=winner, and goes to OFFER. REQ_ID_VALID=1 from N+1. Latency = 1 cycle.
- OFFER: hold REQ_ID_OUT/REQ_SRC/VALID stable until REQ_ID_VALID&READY_FOR_REQ, then go to IDLE. No grant in the handshake cycle, so throughput is at most 1 request per 2 cycles.
- ENABLE deassert in OFFER: the held request still completes; no further grants.
- ENABLE deassert in IDLE: no grant.
- OUTSTANDING: +1 on source handshake; -1 on TX_TVALID&TX_TREADY&TX_TLAST; unchanged if both occur in the same cycle.
- Completion at OUTSTANDING==0: count stays 0 and ERR_UNDERFLOW=1 (sticky until reset). A simultaneous increment still applies (result 1).
- Grant blocked when OUTSTANDING==MAX_OUTSTANDING. A completion in cycle N unblocks arbitration in cycle N+1.
- Sources not granted see READY=0 and hold VALID and ID per AXIS rules. The block never drops or duplicates a request.
- Reset mid-OFFER: the request is discarded and VALID drops asynchronously.

Test Plan:
- All 4 sources valid continuously with IDs 0x10..0x13, READY_FOR_REQ=1, completions every cycle -> output order 0x10,0x11,0x12,0x13,0x10...; REQ_SRC 0,1,2,3,0; REQ_ID_VALID every other cycle.
- Source 2 only valid, ID 0xABCD, READY_FOR_REQ held 0 for 5 cycles -> REQ_ID_OUT=0xABCD stable for 5 cycles; SRC_REQ_READY=0 throughout; single grant.
- MAX_OUTSTANDING=4, no completions, all sources valid -> exactly 4 grants then SRC_REQ_READY=0 and OUTSTANDING=4. One TLAST completion -> a 5th grant occurs the next cycle.
- Grant handshake and TLAST completion in the same cycle with OUTSTANDING=2 -> OUTSTANDING stays 2.
- TLAST completion with OUTSTANDING=0 -> OUTSTANDING=0 and ERR_UNDERFLOW=1 until reset.
- ENABLE=0 while in OFFER with ID 0x55 -> 0x55 still delivered on READY_FOR_REQ; no further grants until ENABLE=1. Assert resetn=0 mid-OFFER -> REQ_ID_VALID=0 immediately.
